sub_share_arbiter: RTL and testbench



---
 rtl/sub_share_arbiter_if.sv | 27 ++
 rtl/sub_share_arbiter.sv | 138 +++++++++++++
 tb/tb_sub_share_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_share_arbiter_if.sv
// Requester and response channels of the shared-subtractor arbiter.
// Clients drive the master side; the arbiter takes the slave side.
interface sub_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_diff;
  logic                  rsp_borrow;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow
  );
endinterface

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational subtractor among
// NREQ requesters and returns tagged results over one response channel.
module sub_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sub_share_arbiter_if.slave bus,
  output logic [WIDTH-1:0]  sub_in1,
  output logic [WIDTH-1:0]  sub_in2,
  input  logic [WIDTH-1:0]  sub_out,
  output logic [15:0]       ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_diff_q;
  logic             rsp_borrow_q;
  logic [15:0]      ops_q;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     cand;
  logic [WIDTH-1:0] gnt_a, gnt_b;
  logic [NREQ-1:0]  req_ready;

  // Search starts one past the last winner; cand < 2*NREQ so a single
  // conditional subtract implements the wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_found && bus.req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_a = bus.req_a[i*WIDTH +: WIDTH];
        gnt_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          state_d            = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer starts at NREQ-1 so the first search after reset begins at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain flops, not a memory array, so all of them take an async reset value.
    if (!rst_n) begin
      rr_ptr_q     <= IDW'(NREQ-1);
      id_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_diff_q   <= '0;
      rsp_borrow_q <= 1'b0;
      ops_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_found) begin
            opa_q    <= gnt_a;
            opb_q    <= gnt_b;
            id_q     <= gnt_idx;
            rr_ptr_q <= gnt_idx;
          end
        end
        EXEC: begin
          rsp_diff_q   <= sub_out;
          rsp_borrow_q <= (opa_q < opb_q);
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ops_q       <= ops_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_diff   = rsp_diff_q;
  assign bus.rsp_borrow = rsp_borrow_q;
  assign sub_in1        = opa_q;
  assign sub_in2        = opb_q;
  assign ops_done       = ops_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Self-checking bench for sub_share_arbiter: directed scenarios plus random
// traffic checked against a transaction-level round-robin model.
module tb_sub_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] sub_in1, sub_in2, sub_out;
  logic [15:0]      ops_done;

  int          checks   = 0;
  int          failures = 0;
  int          rr_m;
  logic [15:0] ops_m;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sub_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  // The shared subtractor the arbiter fronts.
  assign sub_out = sub_in1 - sub_in2;

  sub_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sub_in1  (sub_in1),
    .sub_in2  (sub_in2),
    .sub_out  (sub_out),
    .ops_done (ops_done)
  );

  // First valid requester after the last winner, wrapping around.
  function automatic int exp_grant(input logic [NREQ-1:0] v, input int rr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    return NREQ'(1) << g;
  endfunction

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_m  = NREQ - 1;
    ops_m = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== '0) begin failures++; $display("FAIL reset_rsp_id got=%0h exp=0", bus.rsp_id); end
    checks++; if (bus.rsp_diff !== '0) begin failures++; $display("FAIL reset_rsp_diff got=%0h exp=0", bus.rsp_diff); end
    checks++; if (bus.rsp_borrow !== 1'b0) begin failures++; $display("FAIL reset_rsp_borrow got=%0h exp=0", bus.rsp_borrow); end
    checks++; if (ops_done !== 16'h0000) begin failures++; $display("FAIL reset_ops_done got=%0h exp=0", ops_done); end
    checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%0h exp=0", bus.req_ready); end
    checks++; if (sub_in1 !== '0 || sub_in2 !== '0) begin failures++; $display("FAIL reset_sub_in got=%0h/%0h exp=0/0", sub_in1, sub_in2); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL idle_no_rsp got=%0h exp=0", bus.rsp_valid); end
  endtask

  // Single request and wrap/borrow case, one table row each.
  task automatic test_directed();
    int               ids[2]    = '{0, 2};
    logic [WIDTH-1:0] av[2]     = '{16'h0010, 16'h0001};
    logic [WIDTH-1:0] bv[2]     = '{16'h0003, 16'h0002};
    logic [WIDTH-1:0] dv[2]     = '{16'h000D, 16'hFFFF};
    logic             brw[2]    = '{1'b0, 1'b1};
    int g;
    for (int t = 0; t < 2; t++) begin
      set_req(ids[t], av[t], bv[t]);
      bus.req_valid = onehot(ids[t]);
      g = exp_grant(bus.req_valid, rr_m);
      #1;
      checks++; if (bus.req_ready !== onehot(g)) begin failures++; $display("FAIL dir%0d_req_ready got=%0h exp=%0h", t, bus.req_ready, onehot(g)); end
      @(posedge clk); rr_m = g;
      @(negedge clk); bus.req_valid = '0; #1;
      checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL dir%0d_ready_pulse got=%0h exp=0", t, bus.req_ready); end
      checks++; if (sub_in1 !== av[t] || sub_in2 !== bv[t]) begin failures++; $display("FAIL dir%0d_sub_in got=%0h/%0h exp=%0h/%0h", t, sub_in1, sub_in2, av[t], bv[t]); end
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early_rsp got=%0h exp=0", t, bus.rsp_valid); end
      @(negedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL dir%0d_rsp_valid got=%0h exp=1", t, bus.rsp_valid); end
      checks++; if (bus.rsp_id !== IDW'(ids[t])) begin failures++; $display("FAIL dir%0d_rsp_id got=%0h exp=%0h", t, bus.rsp_id, ids[t]); end
      checks++; if (bus.rsp_diff !== dv[t]) begin failures++; $display("FAIL dir%0d_rsp_diff got=%0h exp=%0h", t, bus.rsp_diff, dv[t]); end
      checks++; if (bus.rsp_borrow !== brw[t]) begin failures++; $display("FAIL dir%0d_rsp_borrow got=%0h exp=%0h", t, bus.rsp_borrow, brw[t]); end
      bus.rsp_ready = 1'b1;
      @(negedge clk); ops_m++; #1;
      checks++; if (ops_done !== ops_m) begin failures++; $display("FAIL dir%0d_ops_done got=%0h exp=%0h", t, ops_done, ops_m); end
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_rsp_drop got=%0h exp=0", t, bus.rsp_valid); end
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int g, prev_acc, acc;
    logic [WIDTH-1:0] ea, eb;
    logic [WIDTH:0]   full;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom));
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    prev_acc = 0;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = exp_grant(bus.req_valid, rr_m);
      checks++; if (bus.req_ready !== onehot(g)) begin failures++; $display("FAIL rr%0d_grant got=%0h exp=%0h", n, bus.req_ready, onehot(g)); end
      ea = bus.req_a[g*WIDTH +: WIDTH];
      eb = bus.req_b[g*WIDTH +: WIDTH];
      acc = cyc;
      if (n > 0) begin
        checks++; if (acc - prev_acc !== 3) begin failures++; $display("FAIL rr%0d_spacing got=%0d exp=3", n, acc - prev_acc); end
      end
      prev_acc = acc;
      @(posedge clk); rr_m = g;
      @(negedge clk); set_req(g, WIDTH'($urandom), WIDTH'($urandom)); #1;
      checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL rr%0d_exec_ready got=%0h exp=0", n, bus.req_ready); end
      @(negedge clk); #1;
      full = {1'b0, ea} - {1'b0, eb};
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(g)) begin failures++; $display("FAIL rr%0d_rsp got=v%0h id%0h exp=v1 id%0h", n, bus.rsp_valid, bus.rsp_id, g); end
      checks++; if (bus.rsp_diff !== full[WIDTH-1:0] || bus.rsp_borrow !== (ea < eb)) begin failures++; $display("FAIL rr%0d_result got=%0h/%0h exp=%0h/%0h", n, bus.rsp_diff, bus.rsp_borrow, full[WIDTH-1:0], ea < eb); end
      @(negedge clk); ops_m++; #1;
      checks++; if (ops_done !== ops_m) begin failures++; $display("FAIL rr%0d_ops got=%0h exp=%0h", n, ops_done, ops_m); end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    checks++; if (ops_done !== 16'd5) begin failures++; $display("FAIL rr_total_ops got=%0d exp=5", ops_done); end
  endtask

  task automatic test_back_pressure();
    logic [WIDTH-1:0] ea, eb;
    logic [WIDTH:0]   full;
    int g;
    set_req(3, WIDTH'($urandom), WIDTH'($urandom));
    bus.req_valid = onehot(3);
    g  = exp_grant(bus.req_valid, rr_m);
    ea = bus.req_a[3*WIDTH +: WIDTH];
    eb = bus.req_b[3*WIDTH +: WIDTH];
    full = {1'b0, ea} - {1'b0, eb};
    #1;
    checks++; if (bus.req_ready !== onehot(g)) begin failures++; $display("FAIL bp_grant3 got=%0h exp=%0h", bus.req_ready, onehot(g)); end
    @(posedge clk); rr_m = g;
    @(negedge clk);
    set_req(1, WIDTH'($urandom), WIDTH'($urandom));
    bus.req_valid = onehot(1);
    @(negedge clk);
    for (int s = 0; s < 10; s++) begin
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(g)) begin failures++; $display("FAIL bp%0d_hold got=v%0h id%0h exp=v1 id%0h", s, bus.rsp_valid, bus.rsp_id, g); end
      checks++; if (bus.rsp_diff !== full[WIDTH-1:0] || bus.rsp_borrow !== (ea < eb)) begin failures++; $display("FAIL bp%0d_data got=%0h/%0h exp=%0h/%0h", s, bus.rsp_diff, bus.rsp_borrow, full[WIDTH-1:0], ea < eb); end
      checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL bp%0d_ready got=%0h exp=0", s, bus.req_ready); end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); ops_m++; bus.rsp_ready = 1'b0; #1;
    g  = exp_grant(bus.req_valid, rr_m);
    ea = bus.req_a[1*WIDTH +: WIDTH];
    eb = bus.req_b[1*WIDTH +: WIDTH];
    full = {1'b0, ea} - {1'b0, eb};
    checks++; if (ops_done !== ops_m || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=ops%0h v%0h exp=ops%0h v0", ops_done, bus.rsp_valid, ops_m); end
    checks++; if (bus.req_ready !== onehot(g)) begin failures++; $display("FAIL bp_grant1 got=%0h exp=%0h", bus.req_ready, onehot(g)); end
    @(posedge clk); rr_m = g;
    @(negedge clk); bus.req_valid = '0;
    @(negedge clk); #1;
    checks++; if (bus.rsp_id !== IDW'(g) || bus.rsp_diff !== full[WIDTH-1:0]) begin failures++; $display("FAIL bp_req1_rsp got=id%0h %0h exp=id%0h %0h", bus.rsp_id, bus.rsp_diff, g, full[WIDTH-1:0]); end
    bus.rsp_ready = 1'b1;
    @(negedge clk); ops_m++; bus.rsp_ready = 1'b0; #1;
    checks++; if (ops_done !== ops_m) begin failures++; $display("FAIL bp_req1_ops got=%0h exp=%0h", ops_done, ops_m); end
  endtask

  task automatic test_reset_mid();
    int g;
    logic [WIDTH-1:0] ea, eb;
    logic [WIDTH:0]   full;
    set_req(2, WIDTH'($urandom), WIDTH'($urandom));
    bus.req_valid = onehot(2);
    @(posedge clk);
    @(negedge clk); bus.req_valid = '0;
    @(negedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%0h exp=1", bus.rsp_valid); end
    #2 rst_n = 1'b0;
    ops_m = '0;
    rr_m  = NREQ - 1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_async_valid got=%0h exp=0", bus.rsp_valid); end
    checks++; if (ops_done !== ops_m) begin failures++; $display("FAIL rm_ops got=%0h exp=%0h", ops_done, ops_m); end
    @(negedge clk); rst_n = 1'b1;
    set_req(0, WIDTH'($urandom), WIDTH'($urandom));
    bus.req_valid = onehot(0) | onehot(2);
    g  = exp_grant(bus.req_valid, rr_m);
    ea = bus.req_a[g*WIDTH +: WIDTH];
    eb = bus.req_b[g*WIDTH +: WIDTH];
    full = {1'b0, ea} - {1'b0, eb};
    #1;
    checks++; if (bus.req_ready !== onehot(g)) begin failures++; $display("FAIL rm_first_grant got=%0h exp=%0h", bus.req_ready, onehot(g)); end
    @(posedge clk); rr_m = g;
    @(negedge clk); bus.req_valid = '0;
    @(negedge clk); #1;
    checks++; if (bus.rsp_id !== IDW'(g) || bus.rsp_diff !== full[WIDTH-1:0]) begin failures++; $display("FAIL rm_rsp got=id%0h %0h exp=id%0h %0h", bus.rsp_id, bus.rsp_diff, g, full[WIDTH-1:0]); end
    bus.rsp_ready = 1'b1;
    @(negedge clk); ops_m++; bus.rsp_ready = 1'b0; #1;
    checks++; if (ops_done !== ops_m) begin failures++; $display("FAIL rm_ops_after got=%0h exp=%0h", ops_done, ops_m); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0]  v;
    logic [WIDTH-1:0] ea, eb;
    logic [WIDTH:0]   full;
    int g, stall;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = '0; #1;
        checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL rnd%0d_idle_ready got=%0h exp=0", n, bus.req_ready); end
        @(negedge clk); #1;
        checks++; if (ops_done !== ops_m || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_idle got=ops%0h v%0h exp=ops%0h v0", n, ops_done, bus.rsp_valid, ops_m); end
      end
      for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom));
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      bus.req_valid = v;
      g  = exp_grant(v, rr_m);
      ea = bus.req_a[g*WIDTH +: WIDTH];
      eb = bus.req_b[g*WIDTH +: WIDTH];
      full = {1'b0, ea} - {1'b0, eb};
      #1;
      checks++; if (bus.req_ready !== onehot(g)) begin failures++; $display("FAIL rnd%0d_grant got=%0h exp=%0h", n, bus.req_ready, onehot(g)); end
      @(posedge clk); rr_m = g;
      @(negedge clk);
      v = v & NREQ'($urandom);
      v[g] = 1'b0;
      bus.req_valid = v;
      #1;
      checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL rnd%0d_exec_ready got=%0h exp=0", n, bus.req_ready); end
      @(negedge clk);
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        #1;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(g) || bus.req_ready !== '0) begin failures++; $display("FAIL rnd%0d_rsp got=v%0h id%0h rdy%0h exp=v1 id%0h rdy0", n, bus.rsp_valid, bus.rsp_id, bus.req_ready, g); end
        checks++; if (bus.rsp_diff !== full[WIDTH-1:0] || bus.rsp_borrow !== (ea < eb)) begin failures++; $display("FAIL rnd%0d_result got=%0h/%0h exp=%0h/%0h", n, bus.rsp_diff, bus.rsp_borrow, full[WIDTH-1:0], ea < eb); end
        bus.rsp_ready = (s == stall);
        @(negedge clk);
      end
      ops_m++;
      bus.rsp_ready = 1'b0;
      #1;
      checks++; if (ops_done !== ops_m || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_done got=ops%0h v%0h exp=ops%0h v0", n, ops_done, bus.rsp_valid, ops_m); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_counter_wrap();
    int g;
    force dut.ops_q = 16'hFFFF;
    #1 release dut.ops_q;
    ops_m = 16'hFFFF;
    set_req(1, WIDTH'($urandom), WIDTH'($urandom));
    bus.req_valid = onehot(1);
    g = exp_grant(bus.req_valid, rr_m);
    #1;
    checks++; if (bus.req_ready !== onehot(g)) begin failures++; $display("FAIL wrap_grant got=%0h exp=%0h", bus.req_ready, onehot(g)); end
    @(posedge clk); rr_m = g;
    @(negedge clk); bus.req_valid = '0;
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(negedge clk); ops_m++; bus.rsp_ready = 1'b0; #1;
    checks++; if (ops_done !== ops_m) begin failures++; $display("FAIL wrap_ops got=%0h exp=%0h", ops_done, ops_m); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_back_pressure();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
